button_conditioner: RTL and testbench

//   Front-end conditioning for the solo_squash player buttons (pause, new game, down, up).
//   Raw pad inputs are active-high: the chip pulls them low by default and a press drives them high.
//   The block synchronises each raw input into clk, debounces it and drives clean active-low levels.

---
 rtl/button_conditioner.sv | 129 ++++++++++++
 tb/tb_button_conditioner.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Button front end: synchronises each raw active-high pad, debounces it and drives
// registered active-low levels plus one-cycle press/release pulses per channel.
module button_conditioner #(
    parameter int unsigned NUM_KEYS       = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DEBOUNCE_BITS  = 16,
    parameter int unsigned DEBOUNCE_COUNT = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_raw,
    output logic [NUM_KEYS-1:0] keys_n,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse
);

    localparam logic [DEBOUNCE_BITS-1:0] CNT_LAST = DEBOUNCE_BITS'(DEBOUNCE_COUNT - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } state_t;

    logic [NUM_KEYS-1:0]      sync_q [SYNC_STAGES];
    logic [NUM_KEYS-1:0]      s;
    state_t                   state_q [NUM_KEYS];
    state_t                   state_d [NUM_KEYS];
    logic [DEBOUNCE_BITS-1:0] cnt_q   [NUM_KEYS];
    logic [DEBOUNCE_BITS-1:0] cnt_d   [NUM_KEYS];
    logic [NUM_KEYS-1:0]      keys_n_c;
    logic [NUM_KEYS-1:0]      press_c;
    logic [NUM_KEYS-1:0]      release_c;

    // Synchroniser chain; only the first stage ever sees keys_raw.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= keys_raw;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State register, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end
            keys_n        <= '1;
            press_pulse   <= '0;
            release_pulse <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            keys_n        <= keys_n_c;
            press_pulse   <= press_c;
            release_pulse <= release_c;
        end
    end

    // Next-state: a pending state commits only after an unbroken run of the new level.
    always_comb begin
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                RELEASED: begin
                    if (s[i]) begin
                        state_d[i] = PRESS_PEND;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_PEND: begin
                    if (!s[i]) begin
                        state_d[i] = RELEASED;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = PRESSED;
                    end else begin
                        cnt_d[i] = cnt_q[i] + DEBOUNCE_BITS'(1);
                    end
                end
                PRESSED: begin
                    if (!s[i]) begin
                        state_d[i] = RELEASE_PEND;
                        cnt_d[i]   = '0;
                    end
                end
                RELEASE_PEND: begin
                    if (s[i]) begin
                        state_d[i] = PRESSED;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = RELEASED;
                    end else begin
                        cnt_d[i] = cnt_q[i] + DEBOUNCE_BITS'(1);
                    end
                end
                default: begin
                    state_d[i] = RELEASED;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Output decode: level follows the committed side, pulses mark commit transitions.
    always_comb begin
        keys_n_c  = '1;
        press_c   = '0;
        release_c = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            keys_n_c[i]  = !(state_d[i] == PRESSED || state_d[i] == RELEASE_PEND);
            press_c[i]   = (state_q[i] == PRESS_PEND)   && (state_d[i] == PRESSED);
            release_c[i] = (state_q[i] == RELEASE_PEND) && (state_d[i] == RELEASED);
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random key activity, all
// compared against a run-length debounce model fed by a queue of sampled raw levels.
module tb_button_conditioner;

    localparam int unsigned NK = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned DB = 16;
    localparam int unsigned DC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] keys_raw;
    logic [NK-1:0] keys_n;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;

    int checks   = 0;
    int failures = 0;

    // Model: raw samples delayed SS edges, then a level commits once it has
    // disagreed with the committed level on DC+1 consecutive edges.
    bit [NK-1:0] m_q[$];
    bit [NK-1:0] m_held;
    bit [NK-1:0] m_press;
    bit [NK-1:0] m_rel;
    int          m_run [NK];

    button_conditioner #(
        .NUM_KEYS      (NK),
        .SYNC_STAGES   (SS),
        .DEBOUNCE_BITS (DB),
        .DEBOUNCE_COUNT(DC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .keys_raw     (keys_raw),
        .keys_n       (keys_n),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_q.delete();
        for (int k = 0; k < int'(SS); k++) m_q.push_back('0);
        m_held  = '0;
        m_press = '0;
        m_rel   = '0;
        for (int i = 0; i < int'(NK); i++) m_run[i] = 0;
    endfunction

    function automatic void model_edge(input bit [NK-1:0] raw);
        bit [NK-1:0] sv;
        sv = m_q.pop_front();
        m_q.push_back(raw);
        m_press = '0;
        m_rel   = '0;
        for (int i = 0; i < int'(NK); i++) begin
            if (sv[i] != m_held[i]) m_run[i]++;
            else                    m_run[i] = 0;
            if (m_run[i] == int'(DC) + 1) begin
                m_run[i]  = 0;
                m_held[i] = sv[i];
                if (sv[i]) m_press[i] = 1'b1;
                else       m_rel[i]   = 1'b1;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [NK-1:0] got, input logic [NK-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "/keys_n"},  keys_n,        ~m_held);
        check({tag, "/press"},   press_pulse,   m_press);
        check({tag, "/release"}, release_pulse, m_rel);
    endtask

    // One clock: drive raw, take the edge, advance the model, sample 1 ns later.
    task automatic step(input string tag, input logic [NK-1:0] raw);
        keys_raw = raw;
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge(raw);
        #1;
        check_model(tag);
    endtask

    task automatic assert_reset_now(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check({tag, "/rst_keys_n"},  keys_n,        4'b1111);
        check({tag, "/rst_press"},   press_pulse,   4'b0000);
        check({tag, "/rst_release"}, release_pulse, 4'b0000);
    endtask

    initial begin
        int          edge_at;
        int          npress;
        int          nrel;
        int          hold [NK];
        logic [NK-1:0] raw;

        reset    = 1'b0;
        keys_raw = '0;
        model_reset();

        // Async reset with all keys pressed, observed before any clock edge.
        #2;
        keys_raw = 4'b1111;
        assert_reset_now("reset");
        repeat (3) step("reset_hold", 4'b1111);
        step("reset_hold", 4'b0000);
        reset = 1'b0;
        repeat (3) step("idle", 4'b0000);

        // Clean press and release on key 3.
        edge_at = -1; npress = 0;
        for (int e = 0; e < 10; e++) begin
            step("press3", 4'b1000);
            if (press_pulse != 4'b0000) begin npress++; edge_at = e; end
        end
        check_int("press3_edge", edge_at, int'(SS + DC));
        check_int("press3_count", npress, 1);
        edge_at = -1; nrel = 0;
        for (int e = 0; e < 10; e++) begin
            step("rel3", 4'b0000);
            if (release_pulse == 4'b1000) begin nrel++; edge_at = e; end
        end
        check_int("rel3_edge", edge_at, int'(SS + DC));
        check_int("rel3_count", nrel, 1);

        // Bounce on key 0: three high samples then one low, never enough to commit.
        npress = 0;
        for (int e = 0; e < 16; e++) begin
            step("bounce0", (e % 4 == 3) ? 4'b0000 : 4'b0001);
            if (press_pulse != 4'b0000 || release_pulse != 4'b0000 || keys_n != 4'b1111) npress++;
        end
        check_int("bounce0_quiet", npress, 0);
        edge_at = -1;
        for (int e = 0; e < 10; e++) begin
            step("bounce0_hold", 4'b0001);
            if (press_pulse == 4'b0001) edge_at = e;
        end
        check_int("bounce0_commit_edge", edge_at, int'(SS + DC));
        repeat (10) step("rel0", 4'b0000);

        // Simultaneous press on keys 1 and 2.
        edge_at = -1;
        for (int e = 0; e < 10; e++) begin
            step("simul", 4'b0110);
            if (press_pulse == 4'b0110 && keys_n == 4'b1001) edge_at = e;
        end
        check_int("simul_edge", edge_at, int'(SS + DC));
        repeat (10) step("simul_rel", 4'b0000);

        // Reset while key 2 is committed pressed.
        repeat (8) step("hold2", 4'b0100);
        check("hold2_level", keys_n, 4'b1011);
        assert_reset_now("midpress");
        step("midpress_rst", 4'b0100);
        reset = 1'b0;
        edge_at = -1; nrel = 0;
        for (int e = 0; e < 10; e++) begin
            step("repress2", 4'b0100);
            if (press_pulse == 4'b0100) edge_at = e;
            if (release_pulse != 4'b0000) nrel++;
        end
        check_int("repress2_edge", edge_at, int'(SS + DC));
        check_int("repress2_no_release", nrel, 0);
        repeat (10) step("rel2", 4'b0000);

        // Independence: key 2 held while key 1 toggles every two cycles.
        edge_at = -1; npress = 0;
        for (int e = 0; e < 16; e++) begin
            step("indep", ((e / 2) % 2 == 0) ? 4'b0110 : 4'b0100);
            if (press_pulse[2]) edge_at = e;
            if (press_pulse[1] || !keys_n[1]) npress++;
        end
        check_int("indep_key2_edge", edge_at, int'(SS + DC));
        check_int("indep_key1_quiet", npress, 0);
        repeat (10) step("indep_rel", 4'b0000);

        // Random per-key hold lengths around the debounce threshold, with rare resets.
        raw = '0;
        for (int i = 0; i < int'(NK); i++) hold[i] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < int'(NK); i++) begin
                if (hold[i] == 0) begin
                    raw[i]  = ~raw[i];
                    hold[i] = int'($urandom_range(1, 2 * DC + 3));
                end
                hold[i]--;
            end
            if ($urandom_range(0, 99) == 0) begin
                assert_reset_now("rand");
                step("rand_rst", raw);
                reset = 1'b0;
            end else begin
                step("rand", raw);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
